// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling, internal tick divider and valid/ready output.
// Reports framing errors and overruns as single-cycle pulses.
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);
    localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(OVERSAMPLE);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;

    logic          rx_m, rx_s, rx_q;
    logic [DW-1:0] div;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick, mid, last, clr, stop_smp, load;

    always_comb begin
        tick     = (state != IDLE) && (div == DW'(TICK_DIV - 1));
        mid      = tick && (cnt == CW'(OVERSAMPLE / 2 - 1));
        last     = tick && (cnt == CW'(OVERSAMPLE - 1));
        clr      = (state == IDLE) || (state == START ? mid : last);
        stop_smp = (state == STOP) && last;
        load     = stop_smp && rx_s && (!rx_valid || rx_ready);
        state_n  = state;
        case (state)
            IDLE:    if (rx_q && !rx_s) state_n = START;
            START:   if (mid) state_n = rx_s ? IDLE : DATA;
            DATA:    if (last && bit_idx == 3'd7) state_n = STOP;
            default: if (last) state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    // Synchronizer and edge flops reset high so a released reset looks like an idle line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {rx_m, rx_s, rx_q} <= 3'b111;
            div       <= '0;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            {rx_m, rx_s, rx_q} <= {rx, rx_m, rx_s};
            div       <= (state == IDLE || tick) ? '0 : div + 1'b1;
            cnt       <= clr ? '0 : cnt + CW'(tick);
            bit_idx   <= (state == IDLE) ? 3'd0 : bit_idx + 3'((state == DATA) && last);
            shreg     <= ((state == DATA) && last) ? {rx_s, shreg[7:1]} : shreg;
            rx_data   <= load ? shreg : rx_data;
            rx_valid  <= load || (rx_valid && !rx_ready);
            frame_err <= stop_smp && !rx_s;
            overrun   <= stop_smp && rx_s && rx_valid && !rx_ready;
        end
    end

    assign rx_busy = state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven checks of uart_rx with defaults (432 clocks per bit).
// Event counters track transfers and pulses; each check compares their change against hand-computed values.
module tb_uart_rx;
    logic       clk = 0, rst = 1, rx = 1, rx_ready = 1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_busy, frame_err, overrun;
    int         n_chk = 0, n_fail = 0;
    int         n_xfer = 0, n_fe = 0, n_ov = 0, n_busy = 0;
    int         s_xfer, s_fe, s_ov, s_busy;

    uart_rx dut (.clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
                 .rx_ready(rx_ready), .rx_busy(rx_busy), .frame_err(frame_err), .overrun(overrun));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #1;
        if (rx_valid && rx_ready) n_xfer <= n_xfer + 1;
        if (frame_err) n_fe <= n_fe + 1;
        if (overrun) n_ov <= n_ov + 1;
        if (rx_busy) n_busy <= n_busy + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bc;
        logic [7:0] exp_data;
        int         exp_xfer;
        int         exp_fe;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int bc);
        rx = 0;
        wait_clk(bc);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(bc);
        end
        rx = stop;
        wait_clk(bc);
    endtask

    task automatic snap();
        s_xfer = n_xfer; s_fe = n_fe; s_ov = n_ov; s_busy = n_busy;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 432, 8'hA5, 1, 0};
        vecs[1] = '{8'h55, 1'b1, 421, 8'h55, 1, 0};
        vecs[2] = '{8'h55, 1'b1, 443, 8'h55, 1, 0};
        vecs[3] = '{8'h3C, 1'b0, 432, 8'h55, 0, 1};
        vecs[4] = '{8'h00, 1'b1, 432, 8'h00, 1, 0};
        vecs[5] = '{8'hFF, 1'b1, 432, 8'hFF, 1, 0};

        wait_clk(3);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_busy", rx_busy, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overrun", overrun, 0);
        rst = 0;
        wait_clk(20);

        for (int v = 0; v < 6; v++) begin
            snap();
            send(vecs[v].data, vecs[v].stop, vecs[v].bc);
            rx = 1;
            wait_clk(864);
            check($sformatf("vec%0d rx_data", v), rx_data, vecs[v].exp_data);
            check($sformatf("vec%0d transfers", v), n_xfer - s_xfer, vecs[v].exp_xfer);
            check($sformatf("vec%0d frame_err", v), n_fe - s_fe, vecs[v].exp_fe);
            check($sformatf("vec%0d overrun", v), n_ov - s_ov, 0);
            check($sformatf("vec%0d rx_valid idle", v), rx_valid, 0);
        end

        // 100-clock glitch: receiver starts, rejects it at mid start bit
        snap();
        rx = 0;
        wait_clk(100);
        rx = 1;
        wait_clk(864);
        check("glitch busy seen", (n_busy - s_busy) > 0, 1);
        check("glitch busy end", rx_busy, 0);
        check("glitch events", (n_xfer - s_xfer) + (n_fe - s_fe) + (n_ov - s_ov), 0);

        // framing error followed by a line held low: no re-arm until high then low
        snap();
        send(8'h3C, 1'b0, 432);
        check("hold fe", n_fe - s_fe, 1);
        check("hold rx_data kept", rx_data, 8'hFF);
        snap();
        wait_clk(1500);
        check("hold low no start", n_busy - s_busy, 0);
        rx = 1;
        wait_clk(432);
        snap();
        send(8'h12, 1'b1, 432);
        wait_clk(432);
        check("rearm rx_data", rx_data, 8'h12);
        check("rearm transfers", n_xfer - s_xfer, 1);

        // back-to-back frames with consumer stalled: second byte overruns
        rx_ready = 0;
        snap();
        send(8'h3C, 1'b1, 432);
        send(8'hC3, 1'b1, 432);
        wait_clk(432);
        check("ovr rx_data", rx_data, 8'h3C);
        check("ovr rx_valid", rx_valid, 1);
        check("ovr pulses", n_ov - s_ov, 1);
        check("ovr frame_err", n_fe - s_fe, 0);
        rx_ready = 1;
        wait_clk(2);
        check("ovr drain rx_valid", rx_valid, 0);
        check("ovr drain transfers", n_xfer - s_xfer, 1);
        check("ovr drain rx_data", rx_data, 8'h3C);

        // reset in the middle of data bit 4 of 0xFF
        snap();
        rx = 0;
        wait_clk(432);
        rx = 1;
        wait_clk(432 * 4 + 216);
        check("rst mid busy", rx_busy, 1);
        rst = 1;
        wait_clk(1);
        check("rst mid rx_data", rx_data, 8'h00);
        check("rst mid busy cleared", rx_busy, 0);
        wait_clk(4);
        rst = 0;
        wait_clk(432 * 6);
        check("rst abort events", (n_xfer - s_xfer) + (n_fe - s_fe) + (n_ov - s_ov), 0);
        check("rst abort rx_data", rx_data, 8'h00);
        snap();
        send(8'h81, 1'b1, 432);
        wait_clk(432);
        check("post rst rx_data", rx_data, 8'h81);
        check("post rst transfers", n_xfer - s_xfer, 1);
        check("post rst errors", (n_fe - s_fe) + (n_ov - s_ov), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
